// File: rtl/dct_transpose_buf.sv
// dct_transpose_buf: ping-pong 8x8 transpose buffer between
// the row-pass and column-pass 1-D DCT cores.
module dct_transpose_buf #(
  parameter int DW = 12
) (
  input  logic          clk,
  input  logic          rstn,
  input  logic          clr,
  input  logic          in_valid,
  input  logic [DW-1:0] in_data,
  output logic          in_ready,
  output logic          out_valid,
  output logic [DW-1:0] out_data,
  input  logic          out_ready,
  output logic          out_last,
  output logic [7:0]    blk_cnt
);

  localparam logic [5:0] LAST = 6'd63;

  logic [DW-1:0] mem0 [64];
  logic [DW-1:0] mem1 [64];

  logic [1:0]    full;
  logic [1:0]    full_nxt;
  logic          wb;
  logic          rb;
  logic [5:0]    widx;
  logic [5:0]    ridx;

  logic          wr_en;
  logic          rd_en;
  logic          wr_last;
  logic          rd_last;
  logic [5:0]    raddr;
  logic [DW-1:0] rd_word;

  assign in_ready  = !full[wb];
  assign out_valid = full[rb];

  // clr wins over any handshake in the same cycle
  assign wr_en   = in_valid && in_ready && !clr;
  assign rd_en   = out_valid && out_ready && !clr;
  assign wr_last = wr_en && (widx == LAST);
  assign rd_last = rd_en && (ridx == LAST);

  // write row-major, read column-major
  assign raddr = {ridx[2:0], ridx[5:3]};

  always_comb begin
    rd_word = '0;
    unique case (1'b1)
      rb:      rd_word = mem1[raddr];
      default: rd_word = mem0[raddr];
    endcase
  end

  assign out_data = out_valid ? rd_word : '0;
  assign out_last = out_valid && (ridx == LAST);

  always_ff @(posedge clk) begin
    if (wr_en && !wb)
      mem0[widx] <= in_data;
  end

  always_ff @(posedge clk) begin
    if (wr_en && wb)
      mem1[widx] <= in_data;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wb   <= 1'b0;
      widx <= '0;
    end else if (clr) begin
      wb   <= 1'b0;
      widx <= '0;
    end else if (wr_en) begin
      widx <= widx + 6'd1;
      if (wr_last)
        wb <= !wb;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      rb   <= 1'b0;
      ridx <= '0;
    end else if (clr) begin
      rb   <= 1'b0;
      ridx <= '0;
    end else if (rd_en) begin
      ridx <= ridx + 6'd1;
      if (rd_last)
        rb <= !rb;
    end
  end

  // set and clear never target the same bank in one cycle
  always_comb begin
    full_nxt = full;
    if (wr_last)
      full_nxt[wb] = 1'b1;
    if (rd_last)
      full_nxt[rb] = 1'b0;
    if (clr)
      full_nxt = '0;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn)
      full <= '0;
    else
      full <= full_nxt;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn)
      blk_cnt <= '0;
    else if (rd_last)
      blk_cnt <= blk_cnt + 8'd1;
  end

endmodule

// File: tb/tb_dct_transpose_buf.sv
// tb_dct_transpose_buf: directed and random checks of the
// transpose buffer against a queue-based transpose model.
module tb_dct_transpose_buf;

  localparam int DW = 12;

  logic          clk = 1'b0;
  logic          rstn = 1'b0;
  logic          clr = 1'b0;
  logic          in_valid = 1'b0;
  logic [DW-1:0] in_data = '0;
  logic          in_ready;
  logic          out_valid;
  logic [DW-1:0] out_data;
  logic          out_ready = 1'b0;
  logic          out_last;
  logic [7:0]    blk_cnt;

  int checks = 0;
  int errors = 0;

  logic [DW-1:0] q[$];
  logic [DW-1:0] wbuf[64];
  int            wcnt;
  int            rcnt;
  int            nfull;
  logic [7:0]    exp_blk;
  logic          stalled;
  logic [DW-1:0] held_data;
  logic          held_last;

  dct_transpose_buf #(.DW(DW)) dut (
    .clk       (clk),
    .rstn      (rstn),
    .clr       (clr),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_ready  (in_ready),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_ready (out_ready),
    .out_last  (out_last),
    .blk_cnt   (blk_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    q.delete();
    wcnt    = 0;
    rcnt    = 0;
    nfull   = 0;
    stalled = 1'b0;
  endtask

  // one clock cycle; entered and left just after a falling edge
  task automatic cyc(input logic iv, input logic [DW-1:0] d,
                     input logic ordy, input logic c);
    logic acc;
    logic rd;
    in_valid  = iv;
    in_data   = d;
    out_ready = ordy;
    clr       = c;
    #1;
    chk("in_ready", 32'(in_ready), 32'(nfull < 2));
    chk("out_valid", 32'(out_valid), 32'(nfull > 0));
    chk("blk_cnt", 32'(blk_cnt), 32'(exp_blk));
    if (nfull > 0) begin
      chk("out_data", 32'(out_data), 32'(q[0]));
      chk("out_last", 32'(out_last), 32'(rcnt == 63));
    end else begin
      chk("out_data_idle", 32'(out_data), 32'h0);
      chk("out_last_idle", 32'(out_last), 32'h0);
    end
    if (stalled) begin
      chk("hold_data", 32'(out_data), 32'(held_data));
      chk("hold_last", 32'(out_last), 32'(held_last));
    end
    stalled = (nfull > 0) && !ordy && !c;
    if (stalled) begin
      held_data = q[0];
      held_last = (rcnt == 63);
    end
    acc = iv && (nfull < 2);
    rd  = (nfull > 0) && ordy;
    @(posedge clk);
    if (c) begin
      q.delete();
      wcnt  = 0;
      rcnt  = 0;
      nfull = 0;
    end else begin
      if (rd) begin
        void'(q.pop_front());
        rcnt++;
        if (rcnt == 64) begin
          rcnt = 0;
          nfull--;
          exp_blk++;
        end
      end
      if (acc) begin
        wbuf[wcnt] = d;
        wcnt++;
        if (wcnt == 64) begin
          wcnt = 0;
          nfull++;
          for (int col = 0; col < 8; col++)
            for (int row = 0; row < 8; row++)
              q.push_back(wbuf[row*8+col]);
        end
      end
    end
    @(negedge clk);
  endtask

  task automatic drain(input int budget);
    for (int i = 0; i < budget && q.size() > 0; i++)
      cyc(1'b0, '0, 1'b1, 1'b0);
    chk("drain_done", 32'(q.size()), 32'h0);
  endtask

  initial begin
    int acc_total;
    logic iv;
    model_reset();
    exp_blk = '0;

    // reset state
    #1;
    chk("rst_in_ready", 32'(in_ready), 32'h1);
    chk("rst_out_valid", 32'(out_valid), 32'h0);
    chk("rst_out_data", 32'(out_data), 32'h0);
    chk("rst_out_last", 32'(out_last), 32'h0);
    chk("rst_blk_cnt", 32'(blk_cnt), 32'h0);
    repeat (2) @(negedge clk);
    rstn = 1'b1;

    // single block of index values
    for (int i = 0; i < 64; i++)
      cyc(1'b1, DW'(i), 1'b1, 1'b0);
    chk("lat_out_valid", 32'(out_valid), 32'h1);
    chk("first_out", 32'(out_data), 32'h0);
    cyc(1'b0, '0, 1'b1, 1'b0);
    chk("second_out", 32'(out_data), 32'd8);
    drain(80);
    chk("blk_cnt_1", 32'(blk_cnt), 32'd1);

    // four streamed blocks
    for (int i = 0; i < 256; i++)
      cyc(1'b1, DW'(i * 7 + 3), 1'b1, 1'b0);
    drain(80);
    chk("blk_cnt_5", 32'(blk_cnt), 32'd5);

    // both banks fill, extra input refused
    for (int i = 0; i < 128; i++)
      cyc(1'b1, DW'(i + 512), 1'b0, 1'b0);
    for (int i = 0; i < 5; i++)
      cyc(1'b1, DW'(12'hfff), 1'b0, 1'b0);
    chk("full_in_ready", 32'(in_ready), 32'h0);
    drain(200);
    chk("blk_cnt_7", 32'(blk_cnt), 32'd7);

    // random handshakes, 20 blocks
    acc_total = 0;
    for (int i = 0; i < 20000 && acc_total < 1280; i++) begin
      iv = 1'($urandom_range(0, 1));
      if (iv && nfull < 2)
        acc_total++;
      cyc(iv, DW'($urandom), 1'($urandom_range(0, 1)), 1'b0);
    end
    for (int i = 0; i < 3000 && q.size() > 0; i++)
      cyc(1'b0, '0, 1'($urandom_range(0, 1)), 1'b0);
    chk("rand_drained", 32'(q.size()), 32'h0);
    chk("blk_cnt_27", 32'(blk_cnt), 32'd27);

    // clr mid-block, concurrent write dropped
    for (int i = 0; i < 30; i++)
      cyc(1'b1, DW'(i + 900), 1'b1, 1'b0);
    cyc(1'b1, DW'(12'h777), 1'b1, 1'b1);
    chk("clr_blk_cnt", 32'(blk_cnt), 32'd27);
    for (int i = 0; i < 64; i++)
      cyc(1'b1, DW'(i + 100), 1'b1, 1'b0);
    chk("clr_first_out", 32'(out_data), 32'd100);
    drain(80);
    chk("blk_cnt_28", 32'(blk_cnt), 32'd28);

    // reset during drain of block 0 with block 1 full
    for (int i = 0; i < 128; i++)
      cyc(1'b1, DW'(i ^ 12'h5a5), 1'b0, 1'b0);
    for (int i = 0; i < 10; i++)
      cyc(1'b0, '0, 1'b1, 1'b0);
    #2;
    rstn = 1'b0;
    #1;
    chk("mid_rst_out_valid", 32'(out_valid), 32'h0);
    chk("mid_rst_in_ready", 32'(in_ready), 32'h1);
    chk("mid_rst_out_data", 32'(out_data), 32'h0);
    chk("mid_rst_blk_cnt", 32'(blk_cnt), 32'h0);
    model_reset();
    exp_blk = '0;
    @(negedge clk);
    rstn = 1'b1;
    for (int i = 0; i < 5; i++)
      cyc(1'b0, '0, 1'b1, 1'b0);
    for (int i = 0; i < 64; i++)
      cyc(1'b1, DW'(i + 2000), 1'b1, 1'b0);
    chk("post_rst_first", 32'(out_data), 32'd2000);
    drain(80);
    chk("blk_cnt_after_rst", 32'(blk_cnt), 32'd1);

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule

// File: doc/dct_transpose_buf.md
DCT_TRANSPOSE_BUF -- requirements
Module: dct_transpose_buf

Interface
REQ-001 The block SHALL have a single clock and an asynchronous, active-low reset, named clk and rstn.
REQ-002 Parameter DW, default 12, SHALL set the coefficient width, matching the 1-D DCT core output.
REQ-003 Block size SHALL be fixed at 8x8, i.e. 64 coefficients per block; it is not a parameter.
REQ-004 The block SHALL have the following ports:
- clk  in  1  clock, rising edge
- rstn  in  1  asynchronous active-low reset
- clr  in  1  synchronous flush
- in_valid  in  1  upstream coefficient valid
- in_data  in  DW  row-pass DCT coefficient, row-major order
- in_ready  out  1  buffer can accept a coefficient
- out_valid  out  1  transposed coefficient valid
- out_data  out  DW  coefficient, column-major order
- out_ready  in  1  downstream (column-pass DCT) accepts
- out_last  out  1  marks the 64th coefficient of a block
- blk_cnt  out  8  count of blocks fully drained

Function
REQ-005 Storage SHALL be two banks (ping-pong) of 64 x DW flops, with one full flag per bank.
REQ-006 Write side: pointer wb (bank select) and widx (6-bit); a write occurs when in_valid && in_ready.
REQ-007 A write SHALL store in_data at mem[wb][widx]; widx[5:3] = row, widx[2:0] = column.
REQ-008 in_ready SHALL equal !full[wb], using the registered flag.
REQ-009 A write with widx==63 SHALL set full[wb], toggle wb and wrap widx to 0 at the same edge.
REQ-010 Read side: pointer rb and ridx (6-bit). out_valid SHALL equal full[rb].
REQ-011 out_data SHALL equal mem[rb][{ridx[2:0], ridx[5:3]}] when out_valid is high, else 0.
REQ-012 A read transfer occurs when out_valid && out_ready; it increments ridx.
REQ-013 A read transfer with ridx==63 SHALL clear full[rb], toggle rb, wrap ridx to 0 and increment blk_cnt (mod 256).
REQ-014 out_last SHALL equal out_valid && (ridx==63).
REQ-015 Latency: out_valid SHALL rise on the clock edge that accepts the 64th input of a block, so the first transposed coefficient is visible 1 cycle later.
REQ-016 Throughput: with both sides always enabled, the block SHALL sustain 1 coefficient per cycle with no bubbles between blocks.
REQ-017 Simultaneous write and read to different banks SHALL proceed independently.
REQ-018 A bank freed at edge N SHALL become writable at edge N+1 (no same-cycle bypass).
REQ-019 When both banks are full, in_ready SHALL be 0 and in_data SHALL be ignored.
REQ-020 out_data and out_last SHALL hold stable while out_valid && !out_ready.
REQ-021 clr SHALL, at the next edge:
- zero wb, rb, widx and ridx;
- clear both full flags;
- override any concurrent write or read transfer.
REQ-022 clr SHALL leave blk_cnt and memory contents unchanged.

Reset
REQ-023 While rstn is low, the block SHALL hold wb=rb=0, widx=ridx=0, full flags = 0, blk_cnt = 0.
REQ-024 While rstn is low, outputs SHALL be in_ready=1, out_valid=0, out_data=0, out_last=0; memory contents are not reset.
REQ-025 Reset asserted mid-block SHALL discard all partial and full blocks; after release, the next accepted input is row 0, column 0.

Verification
REQ-026 After reset, write 64 inputs with value = index (0..63), out_ready=1 -> out_valid rises 1 cycle after the last write; outputs read 0,8,16,...,56,1,9,...,63; out_last only on 63; blk_cnt=1.
REQ-027 Streaming of 4 blocks, in_valid and out_ready held at 1 -> in_ready never drops; output has no gaps; blk_cnt=4.
REQ-028 out_ready=0 while 128 inputs are offered -> in_ready=0 after the 128th accept; the 129th value is not stored. Then out_ready=1 -> block 0 drains first, then block 1; in_ready returns 1 the cycle after the first out_last.
REQ-029 Random in_valid/out_ready (50% each) over 20 blocks -> output matches a reference transpose model; out_data stable while stalled.
REQ-030 clr asserted after 30 writes, concurrent with a write -> that write is dropped; next block starts at index 0; blk_cnt unchanged.
REQ-031 rstn pulsed low mid-drain of block 0 with block 1 full -> out_valid=0 immediately; no further outputs until 64 new inputs are accepted.
